// File: rtl/chaos_key_gen_pkg.sv
// Purpose : shared types and constants for the chaotic AES key generator.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default map parameter r (Q2.30), the substitute
// value for a zero seed/iterate, whitening LFSR polynomial/seed, and the
// number of bytes harvested per key.
package chaos_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL1 = 2'd2,
        ST_MUL2 = 2'd3
    } state_t;

    // r = 3.99 in unsigned Q2.30
    localparam logic [31:0] R_Q230_DEFAULT = 32'hFF5C28F6;

    // Replaces x whenever it would be 0, since 0 is a fixed point of the map
    localparam logic [31:0] ZERO_SEED_SUB  = 32'h6A09E667;

    localparam logic [15:0] LFSR_POLY      = 16'hB400;
    localparam logic [15:0] LFSR_SEED      = 16'hACE1;

    localparam int          KEY_BYTES      = 16;

    // One step of a right-shifting Galois LFSR
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/chaos_key_gen_if.sv
// Purpose : request/key bundle between a key consumer (master) and chaos_key_gen (slave).
// Latency : n/a (wires only).
// Backpressure: none; requests are single-cycle pulses, the key is level-held.
//
// Signals: iSTART/iNEXT request pulses, iSEED 32-bit Q0.32 seed,
//          oKEY 128-bit key, oKEY_UPDATE pulse, oKEY_VALID sticky flag, oBUSY.
interface chaos_key_gen_if;

    logic         iSTART;
    logic         iNEXT;
    logic [31:0]  iSEED;
    logic [127:0] oKEY;
    logic         oKEY_UPDATE;
    logic         oKEY_VALID;
    logic         oBUSY;

    modport master (
        output iSTART,
        output iNEXT,
        output iSEED,
        input  oKEY,
        input  oKEY_UPDATE,
        input  oKEY_VALID,
        input  oBUSY
    );

    modport slave (
        input  iSTART,
        input  iNEXT,
        input  iSEED,
        output oKEY,
        output oKEY_UPDATE,
        output oKEY_VALID,
        output oBUSY
    );

endinterface

// File: rtl/chaos_key_gen_lfsr16.sv
// Purpose : 16-bit Galois LFSR used to whiten harvested key bytes.
// Latency : next_o is combinational from the current state; state advances on step_i.
// Backpressure: none; load_i has priority over step_i.
//
// Ports: clk_i, rst_i (sync, active-high), load_i (reload seed),
//        step_i (advance one step), next_o (value the LFSR steps to).
module chaos_lfsr16
    import chaos_key_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    output logic [15:0] next_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign next_o = lfsr16_next(lfsr_q);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = LFSR_SEED;
        end else if (step_i) begin
            lfsr_d = next_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/chaos_key_gen.sv
// Purpose : builds a 128-bit AES key by iterating a Q0.32 logistic map and harvesting x[23:16].
// Latency : iSTART -> key 1+2*(WARMUP+16) cycles (161 default); iNEXT -> key 32 cycles.
// Backpressure: none; iNEXT while busy is dropped, iSTART while busy restarts from LOAD.
//
// Ports: iCLK, iRST (sync, active-high), bus (chaos_key_gen_if.slave).
// Parameters: WARMUP (discarded iterations after iSTART), R_Q230 (map parameter r).
// Build option: define CHAOS_KEY_WHITEN_EN to XOR each harvested byte with a 16-bit LFSR.
module chaos_key_gen
    import chaos_key_pkg::*;
#(
    parameter int unsigned WARMUP = 64,
    parameter logic [31:0] R_Q230 = R_Q230_DEFAULT
)
(
    input  logic            iCLK,
    input  logic            iRST,
    chaos_key_gen_if.slave  bus
);

    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    state_t         state_q, state_d;
    logic [31:0]    x_q, x_d;
    logic [31:0]    p_q, p_d;
    logic [WW-1:0]  warm_q, warm_d;
    logic [3:0]     harv_q, harv_d;
    logic [119:0]   s_q, s_d;
    logic [127:0]   key_q, key_d;
    logic           upd_q, upd_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    // Datapath: MUL1 forms x*(1-x) using ~x as 1-x-2^-32, MUL2 scales by r.
    logic [31:0]    x_inv;
    logic [63:0]    prod1;
    logic [63:0]    prod2;
    logic [31:0]    xn;
    logic [31:0]    xn_g;
    logic [7:0]     harv_byte;
    logic           unused_bits;

    assign x_inv = ~x_q;
    assign prod1 = {32'h0, x_q} * {32'h0, x_inv};
    assign prod2 = {32'h0, R_Q230} * {32'h0, p_q};
    // p <= 0.25 and r < 4, so the Q2.30 * Q0.32 product never reaches bit 62
    assign xn    = prod2[61:30];
    assign xn_g  = (xn == 32'h0) ? ZERO_SEED_SUB : xn;

    assign unused_bits = ^{prod1[31:0], prod2[63:62], prod2[29:0]};

`ifdef CHAOS_KEY_WHITEN_EN
    logic        lfsr_load;
    logic        lfsr_step;
    logic [15:0] lfsr_next;

    chaos_lfsr16 u_lfsr (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .next_o (lfsr_next)
    );

    assign harv_byte = xn_g[23:16] ^ lfsr_next[7:0];
`else
    assign harv_byte = xn_g[23:16];
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        p_d     = p_q;
        warm_d  = warm_q;
        harv_d  = harv_q;
        s_d     = s_q;
        key_d   = key_q;
        upd_d   = 1'b0;
        valid_d = valid_q;
`ifdef CHAOS_KEY_WHITEN_EN
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
`endif

        if ((state_q != ST_IDLE) && bus.iSTART) begin
            // Abort: the partial key is abandoned, the published key is untouched.
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iSTART) begin
                        state_d = ST_LOAD;
                    end else if (bus.iNEXT) begin
                        // Continue the orbit from the current x, no warm-up.
                        state_d = ST_MUL1;
                        warm_d  = '0;
                        harv_d  = 4'd0;
                    end
                end
                ST_LOAD: begin
                    x_d     = (bus.iSEED == 32'h0) ? ZERO_SEED_SUB : bus.iSEED;
                    warm_d  = WW'(WARMUP);
                    harv_d  = 4'd0;
                    state_d = ST_MUL1;
`ifdef CHAOS_KEY_WHITEN_EN
                    lfsr_load = 1'b1;
`endif
                end
                ST_MUL1: begin
                    p_d     = prod1[63:32];
                    state_d = ST_MUL2;
                end
                ST_MUL2: begin
                    x_d = xn_g;
                    if (warm_q != '0) begin
                        warm_d  = warm_q - WW'(1);
                        state_d = ST_MUL1;
                    end else begin
                        s_d = {s_q[111:0], harv_byte};
`ifdef CHAOS_KEY_WHITEN_EN
                        lfsr_step = 1'b1;
`endif
                        if (harv_q == 4'(KEY_BYTES - 1)) begin
                            // Whole key lands in one edge so the consumer never sees a mix.
                            key_d   = {s_q, harv_byte};
                            upd_d   = 1'b1;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            harv_d  = harv_q + 4'd1;
                            state_d = ST_MUL1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            x_q     <= 32'h0;
            p_q     <= 32'h0;
            warm_q  <= '0;
            harv_q  <= 4'd0;
            s_q     <= 120'h0;
            key_q   <= 128'h0;
            upd_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            p_q     <= p_d;
            warm_q  <= warm_d;
            harv_q  <= harv_d;
            s_q     <= s_d;
            key_q   <= key_d;
            upd_q   <= upd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.oKEY        = key_q;
    assign bus.oKEY_UPDATE = upd_q;
    assign bus.oKEY_VALID  = valid_q;
    assign bus.oBUSY       = busy_q;

endmodule

// File: tb/tb_chaos_key_gen.sv
// Purpose : self-checking bench for chaos_key_gen (default, WARMUP=0, and r=0 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_chaos_key_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        nxt;
    logic [31:0] seed;

    int tests;
    int fails;
    int cyc;
    int upd_cnt_a;
    int ti;

`ifdef CHAOS_KEY_WHITEN_EN
    localparam logic [7:0] EXP_B0 = 8'h2C;
`else
    localparam logic [7:0] EXP_B0 = 8'h5C;
`endif

    chaos_key_gen_if if_a ();
    chaos_key_gen_if if_b ();
    chaos_key_gen_if if_c ();

    assign if_a.iSTART = start;
    assign if_a.iNEXT  = nxt;
    assign if_a.iSEED  = seed;
    assign if_b.iSTART = start;
    assign if_b.iNEXT  = nxt;
    assign if_b.iSEED  = seed;
    assign if_c.iSTART = start;
    assign if_c.iNEXT  = nxt;
    assign if_c.iSEED  = seed;

    chaos_key_gen #(.WARMUP(64), .R_Q230(32'hFF5C28F6)) u_a (.iCLK(clk), .iRST(rst), .bus(if_a));
    chaos_key_gen #(.WARMUP(0),  .R_Q230(32'hFF5C28F6)) u_b (.iCLK(clk), .iRST(rst), .bus(if_b));
    chaos_key_gen #(.WARMUP(0),  .R_Q230(32'h00000000)) u_c (.iCLK(clk), .iRST(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the map, written from the arithmetic definition.
    function automatic logic [31:0] iter(input logic [31:0] x, input logic [31:0] r);
        logic [31:0] xi;
        logic [63:0] m1;
        logic [63:0] m2;
        logic [31:0] p;
        logic [31:0] xn;
        xi = ~x;
        m1 = {32'h0, x} * {32'h0, xi};
        p  = m1[63:32];
        m2 = {32'h0, r} * {32'h0, p};
        xn = m2[61:30];
        return (xn == 32'h0) ? 32'h6A09E667 : xn;
    endfunction

    function automatic logic [127:0] gen_key(input logic [31:0] r, input int warm,
                                             input logic [31:0] x0, input logic [15:0] l0,
                                             output logic [31:0] x1, output logic [15:0] l1);
        logic [127:0] k;
        logic [31:0]  x;
        logic [15:0]  l;
        logic [7:0]   b;
        k = 128'h0;
        x = x0;
        l = l0;
        for (int i = 0; i < warm; i++) x = iter(x, r);
        for (int i = 0; i < 16; i++) begin
            x = iter(x, r);
            b = x[23:16];
`ifdef CHAOS_KEY_WHITEN_EN
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            b = b ^ l[7:0];
`endif
            k = {k[119:0], b};
        end
        x1 = x;
        l1 = l;
        return k;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (if_a.oKEY_UPDATE === 1'b1) upd_cnt_a++;
    endtask

    typedef struct {
        int   cyc;
        logic start;
        logic nxt;
        logic busy;
        logic upd;
    } vec_t;

    localparam int NV = 12;
    vec_t vec[NV];

    logic [127:0] k1, k2, k3, kb, kc;
    logic [31:0]  mx;
    logic [15:0]  ml;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // At cycle c (after edge c): compare busy/update, then drive start/next for edge c+1.
        vec[0]  = '{0,   1'b0, 1'b0, 1'b0, 1'b0};
        vec[1]  = '{9,   1'b1, 1'b0, 1'b0, 1'b0};
        vec[2]  = '{11,  1'b0, 1'b0, 1'b1, 1'b0};
        vec[3]  = '{100, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[4]  = '{170, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{171, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[6]  = '{172, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[7]  = '{179, 1'b0, 1'b1, 1'b0, 1'b0};
        vec[8]  = '{180, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{211, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[10] = '{212, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[11] = '{213, 1'b0, 1'b0, 1'b0, 1'b0};

        k1 = gen_key(32'hFF5C28F6, 64, 32'h80000000, 16'hACE1, mx, ml);
        k2 = gen_key(32'hFF5C28F6, 0, mx, ml, mx, ml);
        k3 = gen_key(32'hFF5C28F6, 64, 32'h6A09E667, 16'hACE1, mx, ml);
        kb = gen_key(32'hFF5C28F6, 0, 32'h80000000, 16'hACE1, mx, ml);
`ifdef CHAOS_KEY_WHITEN_EN
        kc = gen_key(32'h00000000, 0, 32'h80000000, 16'hACE1, mx, ml);
`else
        kc = {16{8'h09}};
`endif

        tests = 0;
        fails = 0;
        cyc = 0;
        upd_cnt_a = 0;
        rst = 1'b1;
        start = 1'b0;
        nxt = 1'b0;
        seed = 32'h80000000;

        // Reset state
        repeat (3) tick();
        chk("rst_key", if_a.oKEY, 128'h0);
        chk("rst_upd", if_a.oKEY_UPDATE, 1'b0);
        chk("rst_valid", if_a.oKEY_VALID, 1'b0);
        chk("rst_busy", if_a.oBUSY, 1'b0);

        // Reset in the middle of a generation
        rst = 1'b0;
        start = 1'b1;
        cyc = -1;
        upd_cnt_a = 0;
        tick();
        start = 1'b0;
        while (cyc < 99) tick();
        chk("mid_busy_before_rst", if_a.oBUSY, 1'b1);
        chk("mid_b_valid_before_rst", if_b.oKEY_VALID, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_key", if_a.oKEY, 128'h0);
        chk("mid_rst_upd", if_a.oKEY_UPDATE, 1'b0);
        chk("mid_rst_valid", if_a.oKEY_VALID, 1'b0);
        chk("mid_rst_busy", if_a.oBUSY, 1'b0);
        chk("mid_rst_b_valid", if_b.oKEY_VALID, 1'b0);
        chk("mid_rst_no_update", upd_cnt_a, 0);

        // Latency, key stability and iNEXT continuation (table driven)
        rst = 1'b0;
        cyc = -1;
        upd_cnt_a = 0;
        ti = 0;
        while (cyc < 230) begin
            tick();
            start = 1'b0;
            nxt = 1'b0;
            if (ti < NV && vec[ti].cyc == cyc) begin
                chk($sformatf("vec%0d_busy", ti), if_a.oBUSY, vec[ti].busy);
                chk($sformatf("vec%0d_upd", ti), if_a.oKEY_UPDATE, vec[ti].upd);
                start = vec[ti].start;
                nxt = vec[ti].nxt;
                ti++;
            end
            if (cyc == 43) begin
                chk("b_upd_at_43", if_b.oKEY_UPDATE, 1'b1);
                chk("b_first_byte", if_b.oKEY[127:120], EXP_B0);
                chk("b_key", if_b.oKEY, kb);
                chk("c_zero_guard_key", if_c.oKEY, kc);
            end
            if (cyc == 170) chk("a_key_stable_before_upd", if_a.oKEY, 128'h0);
            if (cyc == 171) begin
                chk("a_key1", if_a.oKEY, k1);
                chk("a_valid_after_key1", if_a.oKEY_VALID, 1'b1);
            end
            if (cyc == 211) chk("a_key1_held", if_a.oKEY, k1);
            if (cyc == 212) begin
                chk("a_key2_next", if_a.oKEY, k2);
                tests++;
                if (if_a.oKEY === k1) begin
                    fails++;
                    $display("FAIL a_key2_differs: got %h required different from %h", if_a.oKEY, k1);
                end
            end
        end
        chk("a_update_count", upd_cnt_a, 2);

        // Restart with a zero seed mid-generation, plus an ignored iNEXT
        seed = 32'h12345678;
        start = 1'b1;
        cyc = -1;
        upd_cnt_a = 0;
        tick();
        start = 1'b0;
        while (cyc < 49) tick();
        seed = 32'h00000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 99) tick();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
        chk("restart_busy_at_100", if_a.oBUSY, 1'b1);
        while (cyc < 210) tick();
        chk("restart_no_early_update", upd_cnt_a, 0);
        chk("restart_old_key_held", if_a.oKEY, k2);
        tick();
        chk("restart_upd_at_211", if_a.oKEY_UPDATE, 1'b1);
        chk("restart_zero_seed_key", if_a.oKEY, k3);
        while (cyc < 260) tick();
        chk("restart_single_update", upd_cnt_a, 1);
        chk("restart_idle_busy", if_a.oBUSY, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
